// File: rtl/seven_seg_arbiter_pkg.sv
// Shared definitions for the seven-segment display arbiter: FSM state
// encodings, client count, per-client digit slice width and a one-hot helper.
package seven_seg_arbiter_pkg;

    localparam int NUM_CLIENTS   = 4;
    localparam int DIGIT_SLICE_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_OWN  = 2'd2
    } state_t;

    // One-hot decode of a 2-bit client index.
    function automatic logic [NUM_CLIENTS-1:0] onehot(input logic [1:0] idx);
        logic [NUM_CLIENTS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/seven_seg_arbiter_if.sv
// Client-side bundle of the display arbiter: request/data in, grant,
// owner, blank flag and the four digit nibbles out to the scan driver.
interface seven_seg_arbiter_if;
    import seven_seg_arbiter_pkg::*;

    logic [NUM_CLIENTS-1:0]               i_Req;
    logic [NUM_CLIENTS*DIGIT_SLICE_W-1:0] i_Data;
    logic [NUM_CLIENTS-1:0]               o_Grant;
    logic [1:0]                           o_Owner;
    logic                                 o_Blank;
    logic [3:0]                           o_Digit_1;
    logic [3:0]                           o_Digit_2;
    logic [3:0]                           o_Digit_3;
    logic [3:0]                           o_Digit_4;

    // Arbiter side
    modport slave (
        input  i_Req, i_Data,
        output o_Grant, o_Owner, o_Blank,
               o_Digit_1, o_Digit_2, o_Digit_3, o_Digit_4
    );

    // Requesting-client side
    modport master (
        output i_Req, i_Data,
        input  o_Grant, o_Owner, o_Blank,
               o_Digit_1, o_Digit_2, o_Digit_3, o_Digit_4
    );

endinterface

// File: rtl/seven_seg_rr_pick.sv
// Combinational round-robin pick: first requesting client searching
// last+1, last+2, ... modulo 4. The last owner itself is searched last.
module seven_seg_rr_pick
    import seven_seg_arbiter_pkg::*;
(
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [1:0]             last,
    output logic [1:0]             pick,
    output logic                   any_req
);

    logic [1:0]             cand [NUM_CLIENTS];
    logic [NUM_CLIENTS-1:0] hit;

    // Candidate at search distance gi+1 from the last owner
    generate
        for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_cand
            assign cand[gi] = last + 2'(gi + 1);
            assign hit[gi]  = req[cand[gi]];
        end
    endgenerate

    // Nearest hit wins: scan from farthest to nearest so the nearest overwrites
    always_comb begin
        pick = '0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                pick = cand[i];
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/seven_seg_arbiter.sv
// Time-shares the 4-digit seven-segment display between four clients.
// Round-robin ownership with a fixed slice, separated by blank gaps to
// avoid ghosting. All outputs are registered.
// Optional build macro SEVEN_SEG_ARB_PRIORITY_EN: client 0 becomes urgent
// and preempts any other owner on the next edge.
module seven_seg_arbiter
    import seven_seg_arbiter_pkg::*;
#(
    parameter int c_Slice        = 100_000_000,
    parameter int c_Blank_Cycles = 1000,
    parameter int c_Cnt_Width    = 32
) (
    input  logic                i_Clk,
    input  logic                i_Reset,
    seven_seg_arbiter_if.slave  bus
);

    localparam logic [c_Cnt_Width-1:0] BLANK_LAST = c_Cnt_Width'(c_Blank_Cycles - 1);
    localparam logic [c_Cnt_Width-1:0] SLICE_LAST = c_Cnt_Width'(c_Slice - 1);
    localparam logic [c_Cnt_Width-1:0] CNT_ONE    = c_Cnt_Width'(1);

    state_t                   state_reg,  state_next;
    logic [c_Cnt_Width-1:0]   cnt_reg,    cnt_next;
    logic [1:0]               pend_reg,   pend_next;
    logic [1:0]               last_reg,   last_next;
    logic [NUM_CLIENTS-1:0]   grant_reg,  grant_next;
    logic [1:0]               owner_reg,  owner_next;
    logic                     blank_reg,  blank_next;
    logic [DIGIT_SLICE_W-1:0] digits_reg, digits_next;

    logic [1:0]               pick;
    logic                     any_req;
    logic                     owner_req;
    logic                     other_req;
    logic                     urgent;
    logic [DIGIT_SLICE_W-1:0] slices [NUM_CLIENTS];

    seven_seg_rr_pick u_pick (
        .req     (bus.i_Req),
        .last    (last_reg),
        .pick    (pick),
        .any_req (any_req)
    );

    // Split the flat data bus into one 16-bit digit slice per client
    generate
        for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_slice
            assign slices[gi] = bus.i_Data[gi*DIGIT_SLICE_W +: DIGIT_SLICE_W];
        end
    endgenerate

    assign owner_req = bus.i_Req[owner_reg];
    assign other_req = |(bus.i_Req & ~onehot(owner_reg));

`ifdef SEVEN_SEG_ARB_PRIORITY_EN
    assign urgent = (owner_reg != 2'd0) && bus.i_Req[0];
`else
    assign urgent = 1'b0;
`endif

    // State and registered-output update; r_Last resets to 3 so client 0 wins first
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            pend_reg   <= '0;
            last_reg   <= 2'd3;
            grant_reg  <= '0;
            owner_reg  <= '0;
            blank_reg  <= 1'b1;
            digits_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            pend_reg   <= pend_next;
            last_reg   <= last_next;
            grant_reg  <= grant_next;
            owner_reg  <= owner_next;
            blank_reg  <= blank_next;
            digits_reg <= digits_next;
        end
    end

    // Next-state and next-output logic for IDLE / GAP / OWN
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        pend_next   = pend_reg;
        last_next   = last_reg;
        grant_next  = grant_reg;
        owner_next  = owner_reg;
        blank_next  = blank_reg;
        digits_next = digits_reg;

        case (state_reg)
            ST_IDLE: begin
                blank_next  = 1'b1;
                grant_next  = '0;
                digits_next = '0;
                if (any_req) begin
                    pend_next  = pick;
                    cnt_next   = '0;
                    state_next = ST_GAP;
                end
            end

            ST_GAP: begin
                blank_next  = 1'b1;
                grant_next  = '0;
                digits_next = '0;
                cnt_next    = cnt_reg + CNT_ONE;
                if (cnt_reg == BLANK_LAST) begin
                    cnt_next = '0;
                    if (bus.i_Req[pend_reg]) begin
                        state_next  = ST_OWN;
                        grant_next  = onehot(pend_reg);
                        owner_next  = pend_reg;
                        last_next   = pend_reg;
                        blank_next  = 1'b0;
                        digits_next = slices[pend_reg];
                    end else begin
                        // Pending client gave up during the gap: never granted
                        state_next = ST_IDLE;
                    end
                end
            end

            ST_OWN: begin
                digits_next = slices[owner_reg];
                if (cnt_reg != SLICE_LAST) begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
                // Release outranks any preemption on the same edge
                if (!owner_req) begin
                    grant_next  = '0;
                    blank_next  = 1'b1;
                    digits_next = '0;
                    cnt_next    = '0;
                    if (any_req) begin
                        pend_next  = pick;
                        state_next = ST_GAP;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else if (urgent) begin
                    grant_next  = '0;
                    blank_next  = 1'b1;
                    digits_next = '0;
                    cnt_next    = '0;
                    pend_next   = 2'd0;
                    state_next  = ST_GAP;
                end else if ((cnt_reg == SLICE_LAST) && other_req) begin
                    // Owner is searched last by the pick, so pick is another client
                    grant_next  = '0;
                    blank_next  = 1'b1;
                    digits_next = '0;
                    cnt_next    = '0;
                    pend_next   = pick;
                    state_next  = ST_GAP;
                end
            end

            default: begin
                state_next  = ST_IDLE;
                grant_next  = '0;
                blank_next  = 1'b1;
                digits_next = '0;
                cnt_next    = '0;
            end
        endcase
    end

    assign bus.o_Grant   = grant_reg;
    assign bus.o_Owner   = owner_reg;
    assign bus.o_Blank   = blank_reg;
    assign bus.o_Digit_1 = digits_reg[3:0];
    assign bus.o_Digit_2 = digits_reg[7:4];
    assign bus.o_Digit_3 = digits_reg[11:8];
    assign bus.o_Digit_4 = digits_reg[15:12];

endmodule

// File: tb/tb_seven_seg_arbiter.sv
// Scoreboard bench for seven_seg_arbiter (c_Slice=8, c_Blank_Cycles=2).
// Stimulus pushes expected output snapshots tagged with the clock edge after
// which they must hold; a negedge monitor pops and compares them.
module tb_seven_seg_arbiter;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    typedef struct {
        int          at;
        logic [3:0]  grant;
        logic [1:0]  owner;
        logic        blank;
        logic [15:0] digits;
    } exp_t;

    exp_t sb[$];

    logic watch;
    logic pulse_seen;

    seven_seg_arbiter_if bus ();

    seven_seg_arbiter #(
        .c_Slice        (8),
        .c_Blank_Cycles (2),
        .c_Cnt_Width    (32)
    ) dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] dut_digits();
        return {bus.o_Digit_4, bus.o_Digit_3, bus.o_Digit_2, bus.o_Digit_1};
    endfunction

    task automatic push(input int at, input logic [3:0] g, input logic [1:0] o,
                        input logic b, input logic [15:0] d);
        exp_t e;
        e.at = at; e.grant = g; e.owner = o; e.blank = b; e.digits = d;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check4(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compare every snapshot due at this edge; stale ones count as failures
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.at < cyc) begin
                checks++;
                errors++;
                $display("FAIL late_entry: snapshot for cycle %0d not compared, now %0d", e.at, cyc);
            end else begin
                check4("grant",  {12'h0, bus.o_Grant},  {12'h0, e.grant});
                check4("owner",  {14'h0, bus.o_Owner},  {14'h0, e.owner});
                check4("blank",  {15'h0, bus.o_Blank},  {15'h0, e.blank});
                check4("digits", dut_digits(),          e.digits);
                $display("cycle %0d: grant=%b owner=%0d blank=%b digits=%h", cyc,
                         bus.o_Grant, bus.o_Owner, bus.o_Blank, dut_digits());
            end
        end
        if (watch && bus.o_Grant != 4'b0000) pulse_seen = 1'b1;
    end

    initial begin
        int t, s, r, p;
        cyc        = 0;
        checks     = 0;
        errors     = 0;
        watch      = 1'b0;
        pulse_seen = 1'b0;
        rst        = 1'b1;
        bus.i_Req  = 4'b0000;
        bus.i_Data = '0;

        // Power-on reset state
        wait_cyc(2);
        rst = 1'b0;
        #3;
        check4("rst_grant",  {12'h0, bus.o_Grant}, 16'h0);
        check4("rst_blank",  {15'h0, bus.o_Blank}, 16'h1);
        check4("rst_owner",  {14'h0, bus.o_Owner}, 16'h0);
        check4("rst_digits", dut_digits(),         16'h0);

        // Single client 2: grant 3 edges later, held without contention
        wait_cyc(4);
        t = cyc;
        bus.i_Data[47:32] = 16'h4321;
        bus.i_Req = 4'b0100;
        push(t + 3,   4'b0100, 2'd2, 1'b0, 16'h4321);
        push(t + 4,   4'b0100, 2'd2, 1'b0, 16'h4321);
        push(t + 123, 4'b0100, 2'd2, 1'b0, 16'h4321);
        wait_cyc(t + 123);
        bus.i_Data[47:32] = 16'h8765;
        push(t + 124, 4'b0100, 2'd2, 1'b0, 16'h8765);

        // Asynchronous reset mid-cycle while owning
        wait_cyc(t + 126);
        #2;
        rst = 1'b1;
        bus.i_Req = 4'b0000;
        #1;
        check4("arst_grant",  {12'h0, bus.o_Grant}, 16'h0);
        check4("arst_blank",  {15'h0, bus.o_Blank}, 16'h1);
        check4("arst_owner",  {14'h0, bus.o_Owner}, 16'h0);
        check4("arst_digits", dut_digits(),         16'h0);
        wait_cyc(t + 128);
        rst = 1'b0;

        // Client 3 withdraws during the gap: back to IDLE, never granted
        wait_cyc(t + 130);
        s = cyc;
        bus.i_Data[63:48] = 16'hDEAD;
        bus.i_Req = 4'b1000;
        watch = 1'b1;
        push(s + 3, 4'b0000, 2'd0, 1'b1, 16'h0);
        wait_cyc(s + 1);
        bus.i_Req = 4'b0000;
        push(s + 8, 4'b0000, 2'd0, 1'b1, 16'h0);
        wait_cyc(s + 10);
        watch = 1'b0;
        check4("no_grant_pulse", {15'h0, pulse_seen}, 16'h0);

        // Clients 0 and 1 contend: 8-cycle slices separated by 2 blank cycles
        wait_cyc(s + 12);
        r = cyc;
        bus.i_Data[15:0]  = 16'h0C0A;
        bus.i_Data[31:16] = 16'hB1B2;
        bus.i_Req = 4'b0011;
        push(r + 3,  4'b0001, 2'd0, 1'b0, 16'h0C0A);
        push(r + 10, 4'b0001, 2'd0, 1'b0, 16'h0C0A);
        push(r + 11, 4'b0000, 2'd0, 1'b1, 16'h0000);
        push(r + 12, 4'b0000, 2'd0, 1'b1, 16'h0000);
        push(r + 13, 4'b0010, 2'd1, 1'b0, 16'hB1B2);
        push(r + 20, 4'b0010, 2'd1, 1'b0, 16'hB1B2);
        push(r + 21, 4'b0000, 2'd1, 1'b1, 16'h0000);
        push(r + 23, 4'b0001, 2'd0, 1'b0, 16'h0C0A);
        // Client 1 leaves, then sole owner 0 drops mid-slice
        wait_cyc(r + 23);
        bus.i_Req = 4'b0001;
        push(r + 25, 4'b0001, 2'd0, 1'b0, 16'h0C0A);
        wait_cyc(r + 25);
        bus.i_Req = 4'b0000;
        push(r + 26, 4'b0000, 2'd0, 1'b1, 16'h0000);

        // Client 2 owns; client 0 joins at slice counter 1
        wait_cyc(r + 28);
        p = cyc;
        bus.i_Req = 4'b0100;
        push(p + 3, 4'b0100, 2'd2, 1'b0, 16'h8765);
        push(p + 4, 4'b0100, 2'd2, 1'b0, 16'h8765);
        wait_cyc(p + 4);
        bus.i_Req = 4'b0101;
`ifdef SEVEN_SEG_ARB_PRIORITY_EN
        push(p + 5, 4'b0000, 2'd2, 1'b1, 16'h0000);
        push(p + 7, 4'b0001, 2'd0, 1'b0, 16'h0C0A);
`else
        push(p + 5,  4'b0100, 2'd2, 1'b0, 16'h8765);
        push(p + 10, 4'b0100, 2'd2, 1'b0, 16'h8765);
        push(p + 11, 4'b0000, 2'd2, 1'b1, 16'h0000);
        push(p + 13, 4'b0001, 2'd0, 1'b0, 16'h0C0A);
`endif
        wait_cyc(p + 16);
        bus.i_Req = 4'b0000;
        wait_cyc(p + 20);
        #5;

        // Anything left in the scoreboard was never compared
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL unchecked: snapshot for cycle %0d left in queue", e.at);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_arbiter.md
Name: seven_seg_arbiter

Overview:
Time-shares the single 4-digit seven-segment display between four requesting clients.
- Arbitration is round-robin, with a fixed time slice per client.
- A blank gap is inserted between owners to avoid ghosting.
- The block drives the four digit nibbles and a blank flag into the existing seven-seg scan driver. That driver's anode output is gated by o_Blank at top level.

Parameters:
c_Slice, 100_000_000, OWN cycles before a contended owner is preempted (min 1)
c_Blank_Cycles, 1000, blank cycles between owners (min 1)
c_Cnt_Width, 32, width of the internal slice/gap counter

Ports:
i_Clk  in  1  system clock
i_Reset  in  1  asynchronous, active-high reset
i_Req  in  4  level request per client; bit k = client k
i_Data  in  64  client k digits at [16k+15:16k]; digit 1 = low nibble
o_Grant  out  4  one-hot grant, registered; 0 when no owner
o_Owner  out  2  index of current/last owner
o_Blank  out  1  1 = display must be blanked
o_Digit_1  out  4  digit 1 nibble to scan driver
o_Digit_2  out  4  digit 2 nibble
o_Digit_3  out  4  digit 3 nibble
o_Digit_4  out  4  digit 4 nibble

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is asynchronous and active-high. It takes effect immediately, with no clock edge needed.
  - Reset values: state IDLE; o_Grant=0; o_Owner=0; o_Blank=1; all o_Digit_n=0; counter=0; r_Last=3, so client 0 wins first.
- Round-robin pick: the first requesting client searching r_Last+1, r_Last+2, ... modulo 4. The pick is combinational from i_Req and r_Last.
- FSM states: IDLE, GAP, OWN. All outputs are registered.
- IDLE:
  - o_Blank=1, o_Grant=0, digits=0.
  - If any i_Req bit is set: latch pick into r_Pend, clear counter, go to GAP.
- GAP:
  - o_Blank=1, o_Grant=0, digits=0. Counter increments each cycle.
  - At counter==c_Blank_Cycles-1 with i_Req[r_Pend]=1: go to OWN. On that edge, set o_Grant=onehot(r_Pend), o_Owner=r_Pend, r_Last=r_Pend, o_Blank=0, digits=slice of r_Pend. Clear counter.
  - At counter==c_Blank_Cycles-1 with i_Req[r_Pend]=0: go to IDLE.
- OWN:
  - Digits are reloaded every cycle from the owner's i_Data slice, giving 1-cycle latency.
  - Counter increments and saturates at c_Slice-1.
  - Owner drops its request: release on the next edge. If another request is present, go to GAP with a new pick; else go to IDLE. In both cases clear o_Grant, set o_Blank=1, zero the digits.
  - Owner still requesting, counter==c_Slice-1 and another client requesting: preempt. Go to GAP with the next pick and clear o_Grant.
  - Owner still requesting with no contention: hold indefinitely.
- Latency: a request seen at edge t in IDLE produces a grant at edge t+1+c_Blank_Cycles.
- Requests from non-owners are never acknowledged except through o_Grant.
- Simultaneous release and preempt on the same edge: release takes precedence. The resulting next state is identical either way.

Optional Feature:
SEVEN_SEG_ARB_PRIORITY_EN
- Defined: client 0 is urgent. In OWN with owner≠0, i_Req[0]=1 preempts at the next edge regardless of the counter. It goes to GAP with r_Pend=0, bypassing the round-robin pick. Client 0 is itself still preemptible by the slice rule.
- Undefined: pure round-robin; client 0 has no special treatment.

Decomposition:
- Shared package/include contains: state encodings (IDLE=2'd0, GAP=2'd1, OWN=2'd2), client count constant 4, digit-slice width 16.
- One natural sub-module: seven_seg_rr_pick. It is combinational and takes i_Req and r_Last. It outputs a 2-bit pick and an any-request flag.

Test Plan (c_Slice=8, c_Blank_Cycles=2):
1. Reset asserted mid-sim with no clock edge -> o_Grant=0, o_Blank=1, o_Owner=0, all digits 0 immediately.
2. i_Req=4'b0100 at edge t, i_Data[47:32]=16'h4321 -> at edge t+3: o_Grant=4'b0100, o_Owner=2, o_Blank=0, digits 1/2/3/4 = 1,2,3,4. Grant held for >100 cycles with no contention.
3. i_Req=4'b0011 from reset -> client 0 owns for 8 cycles, then 2 blank cycles, then client 1 for 8 cycles, then client 0 again.
4. Sole owner drops i_Req mid-slice -> next edge: IDLE, o_Grant=0, o_Blank=1, digits 0.
5. Client 3 requests, then deasserts during GAP -> IDLE, no grant pulse ever seen.
6. With SEVEN_SEG_ARB_PRIORITY_EN: client 2 owns, i_Req[0] rises at counter 1 -> grant drops next edge, o_Grant=4'b0001 two cycles later. Without the macro, client 0 waits until counter reaches 7.
